// File: rtl/mcu_pkg.sv
// -----------------------------------------------------------------------------
// mcu_pkg
// Shared definitions for the MCU memory arbiter:
//   arb_state_e        - arbiter FSM state encoding
//   RD_BEATS           - read beats returned by the memory controller per read
//   RD_OFFSET_DEFAULT  - default cycles from mem_ack to the first replayed word
// Optional build macro used by the arbiter: MCU_ARB_RR_EN (round-robin).
// -----------------------------------------------------------------------------
package mcu_pkg;

   localparam int RD_BEATS          = 2;
   localparam int RD_OFFSET_DEFAULT = 5;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CMD_CACHE = 3'd1,
      CMD_DMA   = 3'd2,
      RD_WAIT   = 3'd3,
      REPLAY    = 3'd4
   } arb_state_e;

endpackage

// File: rtl/mcu_rd_replay.sv
// -----------------------------------------------------------------------------
// mcu_rd_replay
// Captures the two read beats of a transaction, times the cache replay window
// and drives mem_datafrommem.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - read command accepted; rearm beat capture
//   capture_en    - arbiter is in RD_WAIT (beats outside it are ignored)
//   replay_en     - arbiter is in REPLAY
//   dma_rd        - current read belongs to the DMA port
//   rd_valid/data - memory-controller read beats
//   last_beat     - final beat is being captured this cycle
//   replay_done   - last replay cycle; arbiter returns to IDLE
//   rd_word       - read data towards the cache (mem_datafrommem)
// -----------------------------------------------------------------------------
module mcu_rd_replay
   import mcu_pkg::*;
#(
   parameter int AW        = 32,
   parameter int RD_OFFSET = RD_OFFSET_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          capture_en,
   input  logic          replay_en,
   input  logic          dma_rd,
   input  logic          rd_valid,
   input  logic [AW-1:0] rd_data,
   output logic          last_beat,
   output logic          replay_done,
   output logic [AW-1:0] rd_word
);

   localparam int CW = $clog2(RD_OFFSET + 2) + 1;

   logic [1:0]    beat_cnt_reg;
   logic [AW-1:0] beat0_reg;
   logic [AW-1:0] beat1_reg;
   logic [AW-1:0] hold_reg;
   logic          dma_show_reg;
   logic [CW-1:0] replay_cnt_reg;
   logic          capture;

   // Anything beyond RD_BEATS beats is dropped by the count guard.
   assign capture     = capture_en && rd_valid && (beat_cnt_reg < 2'(RD_BEATS));
   assign last_beat   = capture && (beat_cnt_reg == 2'(RD_BEATS - 1));
   assign replay_done = replay_en && (replay_cnt_reg == CW'(RD_OFFSET + 1));

   // DMA reads overlay beat1 for a single cycle; otherwise the last cache
   // word stays visible.
   assign rd_word = dma_show_reg ? beat1_reg : hold_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_reg   <= '0;
         beat0_reg      <= '0;
         beat1_reg      <= '0;
         hold_reg       <= '0;
         dma_show_reg   <= 1'b0;
         replay_cnt_reg <= '0;
      end else begin
         dma_show_reg <= last_beat && dma_rd;
         if (start) begin
            beat_cnt_reg <= '0;
         end else if (capture) begin
            if (beat_cnt_reg == 2'd0) begin
               beat0_reg <= rd_data;
            end else begin
               beat1_reg <= rd_data;
            end
            beat_cnt_reg <= beat_cnt_reg + 2'd1;
         end
         // Counter is 0 in the mem_ack cycle; hold_reg is loaded one cycle
         // ahead so the words appear at ack+RD_OFFSET and ack+RD_OFFSET+1.
         if (replay_en) begin
            replay_cnt_reg <= replay_cnt_reg + 1'b1;
            if (replay_cnt_reg == CW'(RD_OFFSET - 1)) begin
               hold_reg <= beat0_reg;
            end else if (replay_cnt_reg == CW'(RD_OFFSET)) begin
               hold_reg <= beat1_reg;
            end
         end else begin
            replay_cnt_reg <= '0;
         end
      end
   end

endmodule

// File: rtl/mcu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mcu_mem_arbiter
// Arbitrates a cache port and a DMA port onto one memory-controller command
// port. Writes are acknowledged after command acceptance; reads collect two
// beats, DMA gets beat1 directly, the cache gets both beats replayed later.
// Build option: define MCU_ARB_RR_EN for round-robin arbitration, otherwise
// fixed priority with the cache over DMA.
// Ports:
//   MCU_CLK, RST            - clock, asynchronous active-low reset
//   mem_* / dma_mcu_access  - cache requester
//   dma_*                   - DMA requester
//   cmd_*                   - command towards the memory controller
//   rd_valid, rd_data       - read beats from the memory controller
// -----------------------------------------------------------------------------
module mcu_mem_arbiter
   import mcu_pkg::*;
#(
   parameter int RD_OFFSET = RD_OFFSET_DEFAULT,
   parameter int AW        = 32
) (
   input  logic          MCU_CLK,
   input  logic          RST,
   input  logic          mem_do_act,
   input  logic          mem_we,
   input  logic [AW-1:0] mem_addr,
   input  logic [AW-1:0] mem_dataintomem,
   output logic          mem_ack,
   output logic [AW-1:0] mem_datafrommem,
   output logic          dma_mcu_access,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [AW-1:0] dma_wdata,
   output logic          dma_ack,
   output logic          cmd_valid,
   input  logic          cmd_ready,
   output logic          cmd_we,
   output logic [AW-1:0] cmd_addr,
   output logic [AW-1:0] cmd_wdata,
   input  logic          rd_valid,
   input  logic [AW-1:0] rd_data
);

   arb_state_e    state_reg, state_next;
   logic [1:0]    sync_reg;
   logic          owner_cache_reg;
   logic          cmd_we_reg;
   logic [AW-1:0] cmd_addr_reg;
   logic [AW-1:0] cmd_wdata_reg;
   logic          mem_ack_reg;
   logic          dma_ack_reg;
   logic          pick_cache, pick_dma;
   logic          grant_cache, grant_dma;
   logic          rd_start, set_mem_ack, set_dma_ack;
   logic          last_beat, replay_done;

   // Reset assertion is immediate; release only takes effect once it has
   // passed two flops, so IDLE cannot be left earlier than that.
   always_ff @(posedge MCU_CLK or negedge RST) begin
      if (!RST) begin
         sync_reg <= 2'b00;
      end else begin
         sync_reg <= {sync_reg[0], 1'b1};
      end
   end

`ifdef MCU_ARB_RR_EN
   logic rr_cache_reg;   // 1: cache wins a tie
   assign pick_cache = mem_do_act && (!dma_req || rr_cache_reg);
`else
   assign pick_cache = mem_do_act;
`endif
   assign pick_dma = dma_req && !pick_cache;

   always_comb begin
      state_next  = state_reg;
      grant_cache = 1'b0;
      grant_dma   = 1'b0;
      rd_start    = 1'b0;
      set_mem_ack = 1'b0;
      set_dma_ack = 1'b0;
      case (state_reg)
         IDLE: begin
            if (sync_reg[1]) begin
               if (pick_cache) begin
                  state_next  = CMD_CACHE;
                  grant_cache = 1'b1;
               end else if (pick_dma) begin
                  state_next = CMD_DMA;
                  grant_dma  = 1'b1;
               end
            end
         end
         CMD_CACHE, CMD_DMA: begin
            if (cmd_ready) begin
               if (cmd_we_reg) begin
                  state_next  = IDLE;
                  set_mem_ack = owner_cache_reg;
                  set_dma_ack = !owner_cache_reg;
               end else begin
                  state_next = RD_WAIT;
                  rd_start   = 1'b1;
               end
            end
         end
         RD_WAIT: begin
            if (last_beat) begin
               if (owner_cache_reg) begin
                  state_next  = REPLAY;
                  set_mem_ack = 1'b1;
               end else begin
                  state_next  = IDLE;
                  set_dma_ack = 1'b1;
               end
            end
         end
         REPLAY: begin
            if (replay_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge MCU_CLK or negedge RST) begin
      if (!RST) begin
         state_reg       <= IDLE;
         owner_cache_reg <= 1'b0;
         cmd_we_reg      <= 1'b0;
         cmd_addr_reg    <= '0;
         cmd_wdata_reg   <= '0;
         mem_ack_reg     <= 1'b0;
         dma_ack_reg     <= 1'b0;
`ifdef MCU_ARB_RR_EN
         rr_cache_reg    <= 1'b1;
`endif
      end else begin
         state_reg   <= state_next;
         mem_ack_reg <= set_mem_ack;
         dma_ack_reg <= set_dma_ack;
         // Command fields are captured at grant only, so they stay stable
         // for as long as cmd_ready is low.
         if (grant_cache) begin
            owner_cache_reg <= 1'b1;
            cmd_we_reg      <= mem_we;
            cmd_addr_reg    <= mem_addr;
            cmd_wdata_reg   <= mem_dataintomem;
         end else if (grant_dma) begin
            owner_cache_reg <= 1'b0;
            cmd_we_reg      <= dma_we;
            cmd_addr_reg    <= dma_addr;
            cmd_wdata_reg   <= dma_wdata;
         end
`ifdef MCU_ARB_RR_EN
         if (grant_cache) begin
            rr_cache_reg <= 1'b0;
         end else if (grant_dma) begin
            rr_cache_reg <= 1'b1;
         end
`endif
      end
   end

   mcu_rd_replay #(
      .AW        (AW),
      .RD_OFFSET (RD_OFFSET)
   ) u_rd_replay (
      .clk         (MCU_CLK),
      .rst_n       (RST),
      .start       (rd_start),
      .capture_en  (state_reg == RD_WAIT),
      .replay_en   (state_reg == REPLAY),
      .dma_rd      (!owner_cache_reg),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .last_beat   (last_beat),
      .replay_done (replay_done),
      .rd_word     (mem_datafrommem)
   );

   assign mem_ack        = mem_ack_reg;
   assign dma_ack        = dma_ack_reg;
   assign cmd_valid      = (state_reg == CMD_CACHE) || (state_reg == CMD_DMA);
   assign cmd_we         = cmd_we_reg;
   assign cmd_addr       = cmd_addr_reg;
   assign cmd_wdata      = cmd_wdata_reg;
   assign dma_mcu_access = (state_reg == CMD_CACHE) ||
                           (owner_cache_reg && ((state_reg == RD_WAIT) ||
                                                (state_reg == REPLAY)));

endmodule
